gt_set_assoc_cache: RTL
=======================

Name: gt_set_assoc_cache

Overview:
- Parametrised N-way set-associative, read-only cache with true-LRU replacement. Successor to the direct-mapped cache.
- Sits between the core's byte-read port and main memory.
- On a miss it requests a full line from memory and installs it. Any valid line displaced by the fill is pushed to the victim cache on a dedicated evict port.
- Valid/ready request handshake. Explicit miss handling replaces the old "data appears on the memory bus" scheme.

Parameters:
- ADDR_W, 32, address width in bits.
- LINE_BYTES, 32, bytes per line (power of 2). OFF_W = clog2(LINE_BYTES).
- NUM_SETS, 16, number of sets (power of 2). IDX_W = clog2(NUM_SETS).
- WAYS, 2, associativity (power of 2, 1..8). WAYS=1 gives direct-mapped behaviour.

Ports:
- CLK  in  1  clock; all logic on its rising edge.
- RST  in  1  synchronous, active-high reset.
- req_valid  in  1  core read request.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_addr  in  ADDR_W  byte address.
- resp_valid  out  1  one-cycle pulse: resp_data is valid.
- resp_data  out  8  returned byte.
- resp_hit  out  1  qualified by resp_valid; 1 = hit, 0 = serviced by a fill.
- mem_req_valid  out  1  line-fill request, held until mem_resp_valid.
- mem_req_addr  out  ADDR_W  line-aligned address (low OFF_W bits = 0).
- mem_resp_valid  in  1  fill data present (single cycle).
- mem_resp_data  in  LINE_BYTES*8  fill line.
- evict_valid  out  1  one-cycle pulse: displaced line to the victim cache.
- evict_addr  out  ADDR_W  line-aligned address of the displaced line.
- evict_data  out  LINE_BYTES*8  displaced line contents.

Behaviour:
- Address split:
  - offset = addr[OFF_W-1:0]
  - index = addr[OFF_W+IDX_W-1:OFF_W]
  - tag = remaining upper bits
- Byte select: offset 0 = line[LINE_BYTES*8-1 -: 8], i.e. the MSB byte first. This matches the existing direct-mapped convention.
- Storage per (set, way): valid bit, tag, line data, LRU age of width clog2(WAYS).
- Reset, in the cycle RST is high:
  - all valid bits cleared; age[w] = w in every set; FSM goes to IDLE.
  - outputs: req_ready=0 during reset and 1 after; resp_valid=0; resp_hit=0; resp_data=0; mem_req_valid=0; mem_req_addr=0; evict_valid=0; evict_addr=0; evict_data=0.
- FSM states:
  - IDLE: req_ready=1. On acceptance, register the address and go to LOOKUP.
  - LOOKUP: compare the tag against all valid ways of the set.
    - Hit: resp_valid=1, resp_hit=1, resp_data = selected byte; update LRU; go to IDLE.
    - Miss: go to MISS_WAIT.
  - MISS_WAIT: mem_req_valid=1, mem_req_addr = registered line address.
    - On mem_resp_valid: install the line into the victim way and go to FILL.
  - FILL, for one cycle:
    - resp_valid=1, resp_hit=0, resp_data = byte from the new line; update LRU.
    - If the displaced way was valid: evict_valid=1 with its reconstructed address {old tag, index, 0} and its old data. Otherwise evict_valid=0.
    - Go to IDLE.
- Latency:
  - Hit: accepted at cycle N, resp_valid at N+1.
  - Miss: resp_valid and evict_valid in the cycle after mem_resp_valid.
  - Back-to-back hits sustain one request per 2 cycles.
- Victim way selection: the lowest-numbered invalid way if any exists; else the way with age = WAYS-1.
- LRU update on access to way a with old age k:
  - every way with age < k increments; way a gets age 0.
  - ages stay a permutation of 0..WAYS-1.
- Boundary conditions:
  - mem_resp_valid outside MISS_WAIT is ignored.
  - req_valid outside IDLE is not accepted (req_ready=0). The requester must hold req_addr stable until acceptance.
  - RST during MISS_WAIT or FILL:
    - abandons the miss; mem_req_valid is 0 the cycle after RST.
    - a late mem_resp_valid is ignored and no evict is issued.
  - Duplicate tags within a set never occur: a fill only follows a miss.

Test Plan:
1. Defaults; RST 2 cycles, then read 0x0000_0020 → MISS_WAIT with mem_req_addr=0x0000_0020. Supply line with MSB byte 0xA5 → resp_valid, resp_hit=0, resp_data=0xA5; evict_valid=0.
2. Repeat read 0x0000_0021 → resp_valid exactly 1 cycle after acceptance, resp_hit=1, resp_data = second byte of the line; no mem_req_valid.
3. Fill 0x0000_0020, 0x0000_0220, 0x0000_0420 (same set 1, tags 0/1/2). Third fill evicts the LRU way → evict_valid=1, evict_addr=0x0000_0020, evict_data = first line.
4. LRU check: fill 0x020, fill 0x220, hit 0x020, then miss 0x420 → evict_addr=0x0000_0220.
5. RST asserted mid MISS_WAIT, then mem_resp_valid pulsed → no resp_valid, no evict_valid. A subsequent read of the same address misses again.
6. WAYS=1 build: alternate 0x020/0x220 → every access misses; each fill after the first evicts the other line.

Source files
------------

// File: rtl/gt_set_assoc_cache.sv
`default_nettype none
// ============================================================================
// gt_set_assoc_cache : N-way set-associative read-only byte cache, true LRU
// Rev 1.0
// ============================================================================
module gt_set_assoc_cache #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 32,
  parameter int NUM_SETS   = 16,
  parameter int WAYS       = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [ADDR_W-1:0]       i_req_addr,
  output logic                    o_resp_valid,
  output logic [7:0]              o_resp_data,
  output logic                    o_resp_hit,
  output logic                    o_mem_req_valid,
  output logic [ADDR_W-1:0]       o_mem_req_addr,
  input  logic                    i_mem_resp_valid,
  input  logic [LINE_BYTES*8-1:0] i_mem_resp_data,
  output logic                    o_evict_valid,
  output logic [ADDR_W-1:0]       o_evict_addr,
  output logic [LINE_BYTES*8-1:0] o_evict_data
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int LINE_W = LINE_BYTES * 8;
  localparam int AGE_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int WAY_W  = AGE_W;
  localparam logic [AGE_W-1:0] c_AGE_MAX = AGE_W'(WAYS - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOOKUP    = 2'd1,
    S_MISS_WAIT = 2'd2,
    S_FILL      = 2'd3
  } state_t;

  state_t r_state, w_next;

  logic             r_valid [NUM_SETS][WAYS];
  logic [TAG_W-1:0] r_tag   [NUM_SETS][WAYS];
  logic [LINE_W-1:0] r_data [NUM_SETS][WAYS];
  logic [AGE_W-1:0] r_age   [NUM_SETS][WAYS];

  logic [ADDR_W-1:0] r_addr;
  logic [WAY_W-1:0]  r_way;
  logic              r_ev_valid;
  logic [TAG_W-1:0]  r_ev_tag;
  logic [LINE_W-1:0] r_ev_data;

  logic [OFF_W-1:0]  w_off;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit;
  logic [WAY_W-1:0]  w_hit_way;
  logic              w_has_inv;
  logic [WAY_W-1:0]  w_lru_way;
  logic [WAY_W-1:0]  w_vic_way;
  logic [WAY_W-1:0]  w_acc_way;
  logic              w_upd;
  logic              w_fill_now;
  logic [LINE_W-1:0] w_sel_line;
  logic [7:0]        w_byte;

  assign w_off = r_addr[OFF_W-1:0];
  assign w_idx = r_addr[OFF_W+IDX_W-1:OFF_W];
  assign w_tag = r_addr[ADDR_W-1:OFF_W+IDX_W];

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  // Descending scan so the lowest-numbered invalid way wins.
  always_comb begin
    w_has_inv = 1'b0;
    w_lru_way = '0;
    w_vic_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_age[w_idx][w] == c_AGE_MAX) w_lru_way = WAY_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_idx][w]) begin
        w_has_inv = 1'b1;
        w_vic_way = WAY_W'(w);
      end
    end
    if (!w_has_inv) w_vic_way = w_lru_way;
  end

  assign w_fill_now = (r_state == S_MISS_WAIT) && i_mem_resp_valid;
  assign w_upd      = ((r_state == S_LOOKUP) && w_hit) || (r_state == S_FILL);
  assign w_acc_way  = (r_state == S_FILL) ? r_way : w_hit_way;
  assign w_sel_line = r_data[w_idx][w_acc_way];
  // Offset 0 addresses the most-significant byte of the line.
  assign w_byte     = w_sel_line[{~w_off, 3'b000} +: 8];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (i_req_valid) w_next = S_LOOKUP;
      S_LOOKUP:    w_next = w_hit ? S_IDLE : S_MISS_WAIT;
      S_MISS_WAIT: if (i_mem_resp_valid) w_next = S_FILL;
      S_FILL:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_ev_valid <= 1'b0;
      r_way      <= '0;
      r_addr     <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_age[s][w]   <= AGE_W'(w);
        end
      end
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && i_req_valid) r_addr <= i_req_addr;
      if (w_fill_now) begin
        r_valid[w_idx][w_vic_way] <= 1'b1;
        r_way      <= w_vic_way;
        r_ev_valid <= r_valid[w_idx][w_vic_way];
      end
      if (w_upd) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == w_acc_way)
            r_age[w_idx][w] <= '0;
          else if (r_age[w_idx][w] < r_age[w_idx][w_acc_way])
            r_age[w_idx][w] <= r_age[w_idx][w] + AGE_W'(1);
        end
      end
    end
  end

  // Line storage and the evict snapshot need no reset: validity gates them.
  always_ff @(posedge CLK) begin
    if (w_fill_now) begin
      r_ev_tag                  <= r_tag[w_idx][w_vic_way];
      r_ev_data                 <= r_data[w_idx][w_vic_way];
      r_tag[w_idx][w_vic_way]   <= w_tag;
      r_data[w_idx][w_vic_way]  <= i_mem_resp_data;
    end
  end

  always_comb begin
    o_req_ready     = 1'b0;
    o_resp_valid    = 1'b0;
    o_resp_hit      = 1'b0;
    o_resp_data     = 8'h00;
    o_mem_req_valid = 1'b0;
    o_mem_req_addr  = '0;
    o_evict_valid   = 1'b0;
    o_evict_addr    = '0;
    o_evict_data    = '0;
    if (!RST) begin
      case (r_state)
        S_IDLE: o_req_ready = 1'b1;
        S_LOOKUP: begin
          if (w_hit) begin
            o_resp_valid = 1'b1;
            o_resp_hit   = 1'b1;
            o_resp_data  = w_byte;
          end
        end
        S_MISS_WAIT: begin
          o_mem_req_valid = 1'b1;
          o_mem_req_addr  = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        end
        S_FILL: begin
          o_resp_valid = 1'b1;
          o_resp_data  = w_byte;
          if (r_ev_valid) begin
            o_evict_valid = 1'b1;
            o_evict_addr  = {r_ev_tag, w_idx, {OFF_W{1'b0}}};
            o_evict_data  = r_ev_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
